qick_vec_pulse_gen: RTL and testbench

Command-driven generator of the OUT_DW-bit marker/trigger vector that feeds the vector-to-bit splitter. It accepts commands over a valid/ready interface into a small FIFO. Each command forces static levels or timed pulses on any subset of bits, and per-bit down-counters end each pulse after a programmed number of cycles. Output is fully registered so the bit splitter and its pins see glitch-free levels.

---
 rtl/qick_vec_pulse_gen.sv | 155 +++++++++++++++
 tb/tb_qick_vec_pulse_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/qick_vec_pulse_gen.sv
// rtl/qick_vec_pulse_gen.sv - command-queued marker vector generator with per-bit pulse timers
module qick_vec_pulse_gen #(
    parameter int OUT_DW = 16,
    parameter int LEN_W  = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [1:0]                 cmd_mode_i,
    input  logic [OUT_DW-1:0]          cmd_mask_i,
    input  logic [LEN_W-1:0]           cmd_len_i,
    output logic [OUT_DW-1:0]          dout_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     fifo_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        MODE_NOP   = 2'b00,
        MODE_SET   = 2'b01,
        MODE_CLR   = 2'b10,
        MODE_PULSE = 2'b11
    } mode_e;

    logic [1:0]        mode_mem [DEPTH];
    logic [OUT_DW-1:0] mask_mem [DEPTH];
    logic [LEN_W-1:0]  len_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    logic [OUT_DW-1:0]            dout_q, dout_d;
    logic [OUT_DW-1:0][LEN_W-1:0] pcnt_q, pcnt_d;
    logic                         busy_q, busy_d;

    logic              push, pop;
    logic [1:0]        head_mode;
    logic [OUT_DW-1:0] head_mask;
    logic [LEN_W-1:0]  head_len;
    logic [LEN_W-1:0]  pulse_len;
    logic              any_active;

    // Ready looks only at registered occupancy so a same-cycle pop never frees a slot combinationally.
    assign cmd_ready_o = (fcnt_q != CNT_FULL);
    assign dout_o      = dout_q;
    assign busy_o      = busy_q;
    assign fifo_cnt_o  = fcnt_q;

    assign head_mode = mode_mem[rd_ptr_q];
    assign head_mask = mask_mem[rd_ptr_q];
    assign head_len  = len_mem[rd_ptr_q];
    assign pulse_len = (head_len == '0) ? LEN_ONE : head_len;

    always_comb begin
        push     = cmd_valid_i && cmd_ready_o && !clr_i;
        pop      = (fcnt_q != '0) && en_i && !clr_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CNT_ONE;
            2'b01:   fcnt_d = fcnt_q - CNT_ONE;
            default: fcnt_d = fcnt_q;
        endcase

        dout_d = dout_q;
        pcnt_d = pcnt_q;
        for (int i = 0; i < OUT_DW; i++) begin
            if (pcnt_q[i] > LEN_ONE) begin
                pcnt_d[i] = pcnt_q[i] - LEN_ONE;
            end else if (pcnt_q[i] == LEN_ONE) begin
                pcnt_d[i] = '0;
                dout_d[i] = 1'b0;
            end
            // An executing command owns the bit this cycle, overriding expiry.
            if (pop && head_mask[i]) begin
                case (head_mode)
                    MODE_SET: begin
                        dout_d[i] = 1'b1;
                        pcnt_d[i] = '0;
                    end
                    MODE_CLR: begin
                        dout_d[i] = 1'b0;
                        pcnt_d[i] = '0;
                    end
                    MODE_PULSE: begin
                        dout_d[i] = 1'b1;
                        pcnt_d[i] = pulse_len;
                    end
                    default: ;
                endcase
            end
        end

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
            dout_d   = '0;
            pcnt_d   = '0;
        end

        any_active = 1'b0;
        for (int i = 0; i < OUT_DW; i++) begin
            any_active = any_active | (pcnt_d[i] != '0);
        end
        busy_d = (fcnt_d != '0) || any_active;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            dout_q   <= '0;
            pcnt_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            dout_q   <= dout_d;
            pcnt_q   <= pcnt_d;
            busy_q   <= busy_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mode_mem[wr_ptr_q] <= cmd_mode_i;
            mask_mem[wr_ptr_q] <= cmd_mask_i;
            len_mem[wr_ptr_q]  <= cmd_len_i;
        end
    end

endmodule

// File: tb/tb_qick_vec_pulse_gen.sv
// tb/tb_qick_vec_pulse_gen.sv - randomized reference-model bench for qick_vec_pulse_gen
module tb_qick_vec_pulse_gen;

    localparam int OUT_DW = 16;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              en_i;
    logic              clr_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_mode_i;
    logic [OUT_DW-1:0] cmd_mask_i;
    logic [LEN_W-1:0]  cmd_len_i;
    logic [OUT_DW-1:0] dout_o;
    logic              busy_o;
    logic [$clog2(DEPTH):0] fifo_cnt_o;

    qick_vec_pulse_gen #(.OUT_DW(OUT_DW), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clr_i(clr_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_mode_i(cmd_mode_i), .cmd_mask_i(cmd_mask_i), .cmd_len_i(cmd_len_i),
        .dout_o(dout_o), .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]        mode;
        logic [OUT_DW-1:0] mask;
        int                len;
    } cmd_t;

    // Model: each bit is high if statically set, or while the cycle index is before its pulse end.
    cmd_t q[$];
    bit   stat_hi [OUT_DW];
    int   pulse_end [OUT_DW];
    int   t;

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < OUT_DW; i++) begin
            stat_hi[i]   = 1'b0;
            pulse_end[i] = 0;
        end
    endtask

    function automatic logic [OUT_DW-1:0] exp_dout();
        logic [OUT_DW-1:0] v;
        for (int i = 0; i < OUT_DW; i++) v[i] = stat_hi[i] || (t < pulse_end[i]);
        return v;
    endfunction

    function automatic logic exp_busy();
        logic b;
        b = (q.size() != 0);
        for (int i = 0; i < OUT_DW; i++) if (t < pulse_end[i]) b = 1'b1;
        return b;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_dout"}, 32'(dout_o), 32'(exp_dout()));
        chk({tag, "_busy"}, 32'(busy_o), 32'(exp_busy()));
        chk({tag, "_ready"}, 32'(cmd_ready_o), 32'(q.size() < DEPTH));
        chk({tag, "_cnt"}, 32'(fifo_cnt_o), 32'(q.size()));
    endtask

    // Advances the model by one edge using the currently driven inputs, then compares.
    task automatic tick(input string tag);
        bit   do_pop, do_push;
        cmd_t c;
        do_pop  = (q.size() > 0) && en_i && !clr_i;
        do_push = cmd_valid_i && (q.size() < DEPTH) && !clr_i;
        t++;
        if (clr_i) begin
            model_reset();
        end else begin
            if (do_pop) begin
                c = q.pop_front();
                for (int i = 0; i < OUT_DW; i++) begin
                    if (c.mask[i]) begin
                        case (c.mode)
                            2'b01: begin stat_hi[i] = 1'b1; pulse_end[i] = 0; end
                            2'b10: begin stat_hi[i] = 1'b0; pulse_end[i] = 0; end
                            2'b11: begin stat_hi[i] = 1'b0; pulse_end[i] = t + ((c.len == 0) ? 1 : c.len); end
                            default: ;
                        endcase
                    end
                end
            end
            if (do_push) begin
                c.mode = cmd_mode_i;
                c.mask = cmd_mask_i;
                c.len  = int'(cmd_len_i);
                q.push_back(c);
            end
        end
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [OUT_DW-1:0] k, input int l);
        cmd_valid_i = v;
        cmd_mode_i  = m;
        cmd_mask_i  = k;
        cmd_len_i   = LEN_W'(l);
    endtask

    task automatic idle(input int n, input string tag);
        drive(1'b0, 2'b00, '0, 0);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        t        = 0;
        model_reset();
        rst_ni = 1'b0;
        en_i   = 1'b1;
        clr_i  = 1'b0;
        drive(1'b0, 2'b00, '0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_dout", 32'(dout_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_cnt", 32'(fifo_cnt_o), 32'h0);
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", 32'(cmd_ready_o), 32'h1);

        drive(1'b1, 2'b11, 16'h0005, 3);
        tick("t1");
        idle(6, "t1");
        chk("t1_final", 32'(dout_o), 32'h0);

        drive(1'b1, 2'b11, 16'h0001, 0);
        tick("t2a");
        idle(3, "t2a");
        drive(1'b1, 2'b11, 16'h0001, 4);
        tick("t2b");
        idle(2, "t2b");
        drive(1'b1, 2'b11, 16'h0001, 4);
        tick("t2b");
        idle(8, "t2b");

        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'(i % 4), OUT_DW'(16'h0011 << i), i + 1);
            tick("t3_fill");
        end
        chk("t3_full_cnt", 32'(fifo_cnt_o), 32'(DEPTH));
        drive(1'b0, 2'b00, '0, 0);
        en_i = 1'b1;
        idle(10, "t3_drain");

        drive(1'b1, 2'b01, 16'h8000, 0);
        tick("t4");
        drive(1'b1, 2'b11, 16'h8001, 2);
        tick("t4");
        drive(1'b1, 2'b10, 16'h8000, 0);
        tick("t4");
        idle(5, "t4");

        drive(1'b1, 2'b11, 16'h00FF, 100);
        tick("t5");
        en_i = 1'b0;
        drive(1'b1, 2'b01, 16'hFF00, 0);
        tick("t5");
        drive(1'b1, 2'b10, 16'h0F00, 0);
        tick("t5");
        idle(3, "t5");
        clr_i = 1'b1;
        drive(1'b1, 2'b01, 16'hFFFF, 0);
        tick("t5_clr");
        clr_i = 1'b0;
        en_i  = 1'b1;
        chk("t5_clr_dout", 32'(dout_o), 32'h0);
        idle(3, "t5_post");

        drive(1'b1, 2'b11, 16'h0F0F, 20);
        tick("t6");
        drive(1'b1, 2'b01, 16'h1000, 0);
        tick("t6");
        idle(3, "t6");
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("t6_async_dout", 32'(dout_o), 32'h0);
        chk("t6_async_busy", 32'(busy_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("t6_ready", 32'(cmd_ready_o), 32'h1);
        idle(5, "t6_post");

        for (int n = 0; n < 1500; n++) begin
            drive(($urandom % 3) != 0, 2'($urandom % 4),
                  OUT_DW'($urandom & $urandom),
                  (($urandom % 8) == 0) ? int'($urandom % 40) : int'($urandom % 6));
            en_i  = ($urandom % 5) != 0;
            clr_i = ($urandom % 80) == 0;
            tick("rnd");
        end
        clr_i = 1'b0;
        en_i  = 1'b1;
        idle(50, "rnd_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
